// File: rtl/circ_link_port_pkg.sv
// Shared definitions for the circulant link port: link bundle field map and TX state encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package circ_link_port_pkg;

  // Link bundle field map: [PORT_SIZE-1:2] flit, [1] valid, [0] ready.
  localparam int LINK_FLIT_LSB = 2;
  localparam int LINK_VALID    = 1;
  localparam int LINK_READY    = 0;

  // Flit width carried by a link bundle of the given width.
  function automatic int flit_width(input int port_size);
    return port_size - LINK_FLIT_LSB;
  endfunction

  // TX output register state: empty or holding a flit that is offered on the link.
  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

endpackage

// File: rtl/circ_link_port_if.sv
// Core-side handshake bundle of a link port: TX flits into the port, RX flits out of it.
// Latency: n/a (wiring only).
// Backpressure: valid/ready in both directions; transfer when both are high at a clock edge.
interface circ_link_port_if #(
  parameter int FLIT_W = 39 - circ_link_port_pkg::LINK_FLIT_LSB
) ();

  logic [FLIT_W-1:0] tx_flit;
  logic              tx_valid;
  logic              tx_ready;
  logic [FLIT_W-1:0] rx_flit;
  logic              rx_valid;
  logic              rx_ready;

  // Router core side.
  modport master (
    output tx_flit, tx_valid, rx_ready,
    input  tx_ready, rx_flit, rx_valid
  );

  // Link port side.
  modport slave (
    input  tx_flit, tx_valid, rx_ready,
    output tx_ready, rx_flit, rx_valid
  );

endinterface

// File: rtl/circ_link_port_fifo.sv
// Synchronous FIFO used for both directions of the link port.
// Latency: a pushed entry is visible at pop_dat_o the cycle after the push.
// Backpressure: push ignored while full, pop ignored while empty; callers gate on full_o/empty_o.
module circ_link_port_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_dat_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       pop_dat_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign push_ok   = push_i & ~full_o;
  assign pop_ok    = pop_i & ~empty_o;
  assign pop_dat_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Occupancy follows accepted pushes and pops; both in one cycle leave it unchanged.
  always_comb begin
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  // Storage is written only on an accepted push; reads are gated by occupancy so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; occupancy is tracked on its own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/circ_link_port.sv
// Node-side endpoint of one circulant link port: TX FIFO + output register, RX FIFO + ready register.
// Latency: core push -> link valid 2 cycles; link capture -> rx_valid 1 cycle.
// Backpressure: tx_ready drops when the TX FIFO is full; link ready drops unless 2 RX entries stay free.
module circ_link_port
  import circ_link_port_pkg::*;
#(
  parameter int PORT_SIZE = 39,
  parameter int TX_DEPTH  = 4,
  parameter int RX_DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [PORT_SIZE-1:0]      link_o,
  input  logic [PORT_SIZE-1:0]      link_i,
  circ_link_port_if.slave           core_if,
  output logic [$clog2(TX_DEPTH):0] tx_level_o,
  output logic [$clog2(RX_DEPTH):0] rx_level_o
);

  localparam int FLIT_W = flit_width(PORT_SIZE);
  localparam int RX_CW  = $clog2(RX_DEPTH) + 1;

  // Peer-driven link fields.
  logic [FLIT_W-1:0] peer_flit;
  logic              peer_vld;
  logic              peer_rdy;

  assign peer_flit = link_i[PORT_SIZE-1:LINK_FLIT_LSB];
  assign peer_vld  = link_i[LINK_VALID];
  assign peer_rdy  = link_i[LINK_READY];

  // ---------------- TX path ----------------
  logic              tx_push;
  logic              tx_pop;
  logic              tx_full;
  logic              tx_empty;
  logic [FLIT_W-1:0] tx_head;
  tx_state_e         state_q;
  tx_state_e         state_d;
  logic [FLIT_W-1:0] flit_q;
  logic [FLIT_W-1:0] flit_d;
  logic              link_xfer;

  // Held low during reset so the core cannot push into a FIFO that is being cleared.
  assign core_if.tx_ready = ~rst & ~tx_full;
  assign tx_push          = core_if.tx_valid & core_if.tx_ready;
  assign link_xfer        = (state_q == TX_SEND) & peer_rdy;

  circ_link_port_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (tx_push),
    .push_dat_i (core_if.tx_flit),
    .pop_i      (tx_pop),
    .pop_dat_o  (tx_head),
    .full_o     (tx_full),
    .empty_o    (tx_empty),
    .count_o    (tx_level_o)
  );

  // Output register refills from the FIFO when empty or when its flit crosses the link.
  always_comb begin
    state_d = state_q;
    flit_d  = flit_q;
    tx_pop  = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop  = 1'b1;
          flit_d  = tx_head;
          state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        if (link_xfer) begin
          if (!tx_empty) begin
            tx_pop = 1'b1;
            flit_d = tx_head;
          end else begin
            state_d = TX_IDLE;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // ---------------- RX path ----------------
  logic              rx_push;
  logic              rx_pop;
  logic              rx_full;
  logic              rx_empty;
  logic [RX_CW-1:0]  rx_count;
  logic [RX_CW-1:0]  rx_count_nxt;
  logic              rdy_q;
  logic              rdy_d;

  assign rx_push          = peer_vld & rdy_q;
  assign rx_pop           = core_if.rx_ready & ~rx_empty;
  assign core_if.rx_valid = ~rx_empty;
  assign rx_level_o       = rx_count;

  circ_link_port_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (rx_push),
    .push_dat_i (peer_flit),
    .pop_i      (rx_pop),
    .pop_dat_o  (core_if.rx_flit),
    .full_o     (rx_full),
    .empty_o    (rx_empty),
    .count_o    (rx_count)
  );

  // Ready advertises room for two more flits: one may already be in flight when ready falls.
  always_comb begin
    rx_count_nxt = rx_count + RX_CW'(rx_push) - RX_CW'(rx_pop);
    rdy_d        = (rx_count_nxt <= RX_CW'(RX_DEPTH - 2));
  end

  // All link_o bits come from these registers; nothing from link_i reaches link_o combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TX_IDLE;
      flit_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      flit_q  <= flit_d;
      rdy_q   <= rdy_d;
    end
  end

  assign link_o = {flit_q, (state_q == TX_SEND), rdy_q};

  // A push into a full RX FIFO means the peer ignored our ready: a protocol violation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(rx_push && rx_full));
    end
  end

endmodule

// File: tb/tb_circ_link_port.sv
// Bench: two link ports wired back-to-back (A transmits, B receives), directed and random traffic.
// Latency: n/a.
// Backpressure: B's core rx_ready is driven by the bench.
module tb_circ_link_port;
  import circ_link_port_pkg::*;

  localparam int PORT_SIZE = 39;
  localparam int FLIT_W    = PORT_SIZE - 2;
  localparam int DEPTH     = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [PORT_SIZE-1:0] link_ab;
  logic [PORT_SIZE-1:0] link_ba;
  logic [2:0] tx_level_a, rx_level_a, tx_level_b, rx_level_b;
  int errors = 0;
  int checks = 0;

  circ_link_port_if #(.FLIT_W(FLIT_W)) if_a ();
  circ_link_port_if #(.FLIT_W(FLIT_W)) if_b ();

  always #5 clk = ~clk;

  circ_link_port #(.PORT_SIZE(PORT_SIZE), .TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH)) u_a (
    .clk(clk), .rst(rst), .link_o(link_ab), .link_i(link_ba), .core_if(if_a),
    .tx_level_o(tx_level_a), .rx_level_o(rx_level_a)
  );

  circ_link_port #(.PORT_SIZE(PORT_SIZE), .TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH)) u_b (
    .clk(clk), .rst(rst), .link_o(link_ba), .link_i(link_ab), .core_if(if_b),
    .tx_level_o(tx_level_b), .rx_level_o(rx_level_b)
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (link_ab !== '0) begin errors++; $display("FAIL reset_link_a_in_rst: got %h want 0", link_ab); end
    checks++; if (if_a.tx_ready !== 1'b0) begin errors++; $display("FAIL reset_tx_ready_in_rst: got %b want 0", if_a.tx_ready); end
    rst = 1'b0;
    #1;
    checks++; if (if_a.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready_after: got %b want 1", if_a.tx_ready); end
    checks++; if (link_ab !== '0) begin errors++; $display("FAIL reset_link_a: got %h want 0", link_ab); end
    checks++; if (link_ba !== '0) begin errors++; $display("FAIL reset_link_b: got %h want 0", link_ba); end
    checks++; if (if_b.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", if_b.rx_valid); end
    checks++; if ({tx_level_a, rx_level_a, tx_level_b, rx_level_b} !== 12'h0) begin
      errors++; $display("FAIL reset_levels: got %h want 0", {tx_level_a, rx_level_a, tx_level_b, rx_level_b});
    end
    @(negedge clk);
    checks++; if (link_ab !== 39'h1) begin errors++; $display("FAIL reset_ready_rise_a: got %h want 1", link_ab); end
    checks++; if (link_ba !== 39'h1) begin errors++; $display("FAIL reset_ready_rise_b: got %h want 1", link_ba); end
  endtask

  task automatic test_stream();
    int k = 0;
    int got = 0;
    if_b.rx_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++; if (link_ab[LINK_VALID] !== 1'b0) begin errors++; $display("FAIL stream_valid_c1: got %b want 0", link_ab[LINK_VALID]); end
      end
      if (c == 2) begin
        checks++; if (link_ab[LINK_VALID] !== 1'b1) begin errors++; $display("FAIL stream_valid_c2: got %b want 1", link_ab[LINK_VALID]); end
      end
      if (if_b.rx_valid && if_b.rx_ready) begin
        checks++; if (if_b.rx_flit !== FLIT_W'(got + 1)) begin errors++; $display("FAIL stream_data: got %h want %h", if_b.rx_flit, got + 1); end
        checks++; if (c !== got + 3) begin errors++; $display("FAIL stream_timing: flit %0d at cycle %0d want %0d", got + 1, c, got + 3); end
        got++;
      end
      if (k < 8) begin
        if_a.tx_valid = 1'b1;
        if_a.tx_flit  = FLIT_W'(k + 1);
        if (if_a.tx_ready) k++;
      end else begin
        if_a.tx_valid = 1'b0;
      end
    end
    checks++; if (got !== 8) begin errors++; $display("FAIL stream_count: got %0d want 8", got); end
    checks++; if (rx_level_b !== 3'd0) begin errors++; $display("FAIL stream_rx_level_end: got %0d want 0", rx_level_b); end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int got = 0;
    if_b.rx_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (sent < 10) begin
        if_a.tx_valid = 1'b1;
        if_a.tx_flit  = FLIT_W'(16 + sent);
        if (if_a.tx_ready) sent++;
      end else begin
        if_a.tx_valid = 1'b0;
      end
    end
    checks++; if (rx_level_b !== 3'd3) begin errors++; $display("FAIL bp_rx_level: got %0d want 3", rx_level_b); end
    checks++; if (link_ba[LINK_READY] !== 1'b0) begin errors++; $display("FAIL bp_link_ready: got %b want 0", link_ba[LINK_READY]); end
    checks++; if (tx_level_a !== 3'd4) begin errors++; $display("FAIL bp_tx_level: got %0d want 4", tx_level_a); end
    checks++; if (if_a.tx_ready !== 1'b0) begin errors++; $display("FAIL bp_tx_ready: got %b want 0", if_a.tx_ready); end
    checks++; if (link_ab[LINK_VALID] !== 1'b1) begin errors++; $display("FAIL bp_link_valid: got %b want 1", link_ab[LINK_VALID]); end
    checks++; if (sent !== 8) begin errors++; $display("FAIL bp_accepted: got %0d want 8", sent); end
    // Release: the first pop frees an entry, then push and pop coincide and the level holds at 2.
    for (int c = -1; c < 40; c++) begin
      if (c >= 0) @(negedge clk);
      if (c == 0 || c == 1) begin
        checks++; if (rx_level_b !== 3'd2) begin errors++; $display("FAIL bp_release_level_c%0d: got %0d want 2", c, rx_level_b); end
        checks++; if (link_ba[LINK_READY] !== 1'b1) begin errors++; $display("FAIL bp_release_ready_c%0d: got %b want 1", c, link_ba[LINK_READY]); end
      end
      if_b.rx_ready = 1'b1;
      if (if_b.rx_valid) begin
        checks++; if (if_b.rx_flit !== FLIT_W'(16 + got)) begin errors++; $display("FAIL bp_data: got %h want %h", if_b.rx_flit, 16 + got); end
        got++;
      end
      if (sent < 10) begin
        if_a.tx_valid = 1'b1;
        if_a.tx_flit  = FLIT_W'(16 + sent);
        if (if_a.tx_ready) sent++;
      end else begin
        if_a.tx_valid = 1'b0;
      end
    end
    checks++; if (got !== 10) begin errors++; $display("FAIL bp_delivered: got %0d want 10", got); end
    checks++; if ({tx_level_a, rx_level_b} !== 6'h0) begin errors++; $display("FAIL bp_drained: got tx %0d rx %0d want 0 0", tx_level_a, rx_level_b); end
  endtask

  task automatic test_random();
    logic [FLIT_W-1:0] sb[$];
    logic [FLIT_W-1:0] cur = '0;
    logic [FLIT_W-1:0] exp_flit;
    logic offering = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      checks++; if (rx_level_b > 3'd3) begin errors++; $display("FAIL rand_rx_overflow: level %0d want <=3", rx_level_b); end
      if_b.rx_ready = 1'($urandom_range(0, 1));
      if (if_b.rx_valid && if_b.rx_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL rand_unexpected: got %h want none", if_b.rx_flit);
        end else begin
          exp_flit = sb.pop_front();
          if (if_b.rx_flit !== exp_flit) begin errors++; $display("FAIL rand_data: got %h want %h", if_b.rx_flit, exp_flit); end
        end
      end
      if (!offering && $urandom_range(0, 1) == 1) begin
        offering = 1'b1;
        cur = {5'($urandom()), $urandom()};
      end
      if_a.tx_valid = offering;
      if_a.tx_flit  = cur;
      if (offering && if_a.tx_ready) begin
        sb.push_back(cur);
        offering = 1'b0;
      end
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if_a.tx_valid = 1'b0;
      if_b.rx_ready = 1'b1;
      if (if_b.rx_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL rand_drain_unexpected: got %h want none", if_b.rx_flit);
        end else begin
          exp_flit = sb.pop_front();
          if (if_b.rx_flit !== exp_flit) begin errors++; $display("FAIL rand_drain_data: got %h want %h", if_b.rx_flit, exp_flit); end
        end
      end
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL rand_lost: %0d flits undelivered want 0", sb.size()); end
    checks++; if (rx_level_b !== 3'd0) begin errors++; $display("FAIL rand_rx_level_end: got %0d want 0", rx_level_b); end
  endtask

  task automatic test_reset_midflight();
    int sent = 0;
    int stale = 0;
    int got = 0;
    if_b.rx_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (sent < 6) begin
        if_a.tx_valid = 1'b1;
        if_a.tx_flit  = FLIT_W'(32 + sent);
        if (if_a.tx_ready) sent++;
      end else begin
        if_a.tx_valid = 1'b0;
      end
    end
    checks++; if (link_ab[LINK_VALID] !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b want 1", link_ab[LINK_VALID]); end
    checks++; if (tx_level_a !== 3'd2) begin errors++; $display("FAIL mid_pre_tx_level: got %0d want 2", tx_level_a); end
    checks++; if (rx_level_b !== 3'd3) begin errors++; $display("FAIL mid_pre_rx_level: got %0d want 3", rx_level_b); end
    rst = 1'b1;
    if_a.tx_valid = 1'b0;
    @(negedge clk);
    checks++; if (link_ab !== '0) begin errors++; $display("FAIL mid_link_a: got %h want 0", link_ab); end
    checks++; if (tx_level_a !== 3'd0) begin errors++; $display("FAIL mid_tx_level: got %0d want 0", tx_level_a); end
    checks++; if (rx_level_b !== 3'd0) begin errors++; $display("FAIL mid_rx_level: got %0d want 0", rx_level_b); end
    checks++; if (if_b.rx_valid !== 1'b0) begin errors++; $display("FAIL mid_rx_valid: got %b want 0", if_b.rx_valid); end
    checks++; if (if_a.tx_ready !== 1'b0) begin errors++; $display("FAIL mid_tx_ready: got %b want 0", if_a.tx_ready); end
    rst = 1'b0;
    if_b.rx_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (if_b.rx_valid) stale++;
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL mid_stale: got %0d flits want 0", stale); end
    checks++; if (link_ab[LINK_VALID] !== 1'b0) begin errors++; $display("FAIL mid_post_valid: got %b want 0", link_ab[LINK_VALID]); end
    sent = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (if_b.rx_valid) begin
        checks++; if (if_b.rx_flit !== FLIT_W'(85)) begin errors++; $display("FAIL mid_fresh_data: got %h want 55", if_b.rx_flit); end
        got++;
      end
      if (sent == 0) begin
        if_a.tx_valid = 1'b1;
        if_a.tx_flit  = FLIT_W'(85);
        if (if_a.tx_ready) sent++;
      end else begin
        if_a.tx_valid = 1'b0;
      end
    end
    checks++; if (got !== 1) begin errors++; $display("FAIL mid_fresh_count: got %0d want 1", got); end
  endtask

  initial begin
    if_a.tx_valid = 1'b0;
    if_a.tx_flit  = '0;
    if_a.rx_ready = 1'b1;
    if_b.tx_valid = 1'b0;
    if_b.tx_flit  = '0;
    if_b.rx_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
